ap_ctrl_multi_monitor: RTL
==========================

// Module: ap_ctrl_multi_monitor
// PURPOSE
//  Synthesizable N-channel monitor for HLS ap_ctrl_hs/ap_ctrl_chain block handshakes.
//  Per channel it counts accepted starts and completed transactions, and measures start-to-done latency
//  (last/min/max) for up to DEPTH overlapping transactions. It also counts busy and stall cycles.
//  Sits beside the myproject top and its sub-blocks; results are read via a registered readout port.
// PARAMETERS
//  NUM_CH  2   number of monitored modules (1..16)
//  CNT_W   32  width of every counter, timestamp and latency register
//  DEPTH   4   per-channel timestamp FIFO depth, power of 2, >=2 (max in-flight transactions)
// PORTS
//  ap_clk       in   1                 clock, all logic rising-edge
//  ap_rst_n     in   1                 asynchronous active-low reset
//  ap_start     in   NUM_CH            per-channel ap_start
//  ap_ready     in   NUM_CH            per-channel ap_ready
//  ap_done      in   NUM_CH            per-channel ap_done
//  ap_continue  in   NUM_CH            per-channel ap_continue (tie 1 for ap_ctrl_hs)
//  freeze       in   1                 1 = hold all counters/FIFOs (end-of-run snapshot)
//  clr          in   1                 sync pulse: clear all channel state to reset values
//  rd_req       in   1                 read request
//  rd_ch        in   $clog2(NUM_CH)    channel to read (>=NUM_CH reads 0)
//  rd_reg       in   3                 register index, see map
//  rd_valid     out  1                 rd_data valid, 1 cycle after rd_req
//  rd_data      out  CNT_W             read data
//  ch_busy      out  NUM_CH            1 = channel has >=1 transaction in flight
// BEHAVIOUR
//  Reset/clr: counters 0, min_lat all-ones, FIFOs empty, flags 0, rd_valid 0, rd_data 0, ch_busy 0.
//  Free-running timestamp ts (CNT_W, wraps); runs even when freeze=1. clr does not reset ts.
//  Events per channel c:
//   accept = ap_start&ap_ready; push ts, start_cnt++.
//   done   = ap_done&ap_continue; pop ts0, done_cnt++.
//   latency = ts - ts0 (mod 2^CNT_W, wrap-safe); update last_lat, min_lat, max_lat.
//  Same-cycle accept+done with FIFO empty: latency 0 recorded, FIFO stays empty, no error.
//  Same-cycle accept+done with FIFO non-empty: pop head and push new entry together, count unchanged.
//  Overflow: accept while FIFO full -> push dropped, start_cnt still increments, sticky ovf=1.
//   Latencies are untrusted until clr.
//  Underflow: done while FIFO empty (no same-cycle accept) -> done_cnt increments.
//   Latency regs unchanged; sticky udf=1.
//  Channel FSM (informative, drives ch_busy and busy/stall counts):
//   IDLE  -> BUSY on accept without same-cycle done.
//   BUSY  -> STALL when ap_done&~ap_continue.
//   STALL -> BUSY on done with FIFO count>1.
//   STALL -> IDLE on done with FIFO count=1.
//   BUSY  -> IDLE on done with FIFO count=1 and no same-cycle accept.
//  ch_busy = (state != IDLE), registered.
//  busy_cycles++ each cycle state != IDLE.
//  All counters saturate at all-ones; no wrap.
//  freeze=1: no counter, FIFO or flag updates. Handshakes during freeze are ignored, not queued.
//  clr has priority over events in the same cycle. Async reset mid-transaction discards in-flight entries.
//  Register map (rd_reg):
//   0 start_cnt   1 done_cnt   2 last_lat   3 min_lat   4 max_lat   5 busy_cycles   6 stall_cycles
//   7 status = {ovf, udf, fifo_count} LSB-aligned, zero-extended
//  Readout: rd_data/rd_valid registered, 1-cycle latency; reads back-to-back each cycle.
//   Data reflects state before the cycle's own update.
// CONFIGURATION
//  MON_STALL_CNT_EN defined: stall_cycles counts cycles with ap_done&~ap_continue,
//   plus cycles with ap_start&~ap_ready (input wait).
//  Not defined: stall counter logic omitted; STALL state omitted (BUSY holds instead); rd_reg 6 reads 0.
// TESTING
//  Ch0 start+ready at ts=10, done at ts=17 -> start_cnt=1, done_cnt=1, last/min/max_lat=7, ch_busy low after done.
//  Ch1 three overlapped accepts at ts 5,6,7, dones at 20,22,30 -> last_lat=23, min_lat=15, max_lat=23, fifo_count=0.
//  DEPTH=4: five accepts, no done -> ovf=1, start_cnt=5, fifo_count=4; one done with ch empty -> udf=1 after drain.
//  Ch0 ap_done held 4 cycles with ap_continue=0, then continue=1 -> stall_cycles=4 (EN) / 0 (no EN), done_cnt=1.
//  ts near 2^CNT_W-2 at accept, done 5 cycles later after wrap -> last_lat=5;
//   counter forced to all-ones stays saturated.
//  freeze=1 during accept/done -> no counts; clr+accept same cycle -> start_cnt=0; rd_req -> rd_valid next cycle.

Source files
------------

// File: rtl/ap_ctrl_multi_monitor.sv
// N-channel ap_ctrl_hs/ap_ctrl_chain handshake monitor: start/done counts, start-to-done latency
// statistics, busy and stall cycle counts, registered readout. Define MON_STALL_CNT_EN to add the
// STALL state and the stall_cycles counter.
module ap_ctrl_multi_monitor #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              freeze,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_reg,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ch_busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_CW = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY
`ifdef MON_STALL_CNT_EN
    , S_STALL
`endif
  } ch_state_e;

  typedef struct packed {
    ch_state_e         state;
    logic              busy;
    logic              ovf;
    logic              udf;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_CW-1:0] count;
    logic [CNT_W-1:0]  start_cnt;
    logic [CNT_W-1:0]  done_cnt;
    logic [CNT_W-1:0]  last_lat;
    logic [CNT_W-1:0]  min_lat;
    logic [CNT_W-1:0]  max_lat;
    logic [CNT_W-1:0]  busy_cyc;
`ifdef MON_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cyc;
`endif
  } ch_regs_t;

  function automatic ch_regs_t ch_reset();
    ch_regs_t r;
    r         = '0;
    r.state   = S_IDLE;
    r.min_lat = '1;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] ts_q;
  logic [CNT_W-1:0] reg_word [NUM_CH];
  logic [CNT_W-1:0] rd_word;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             upd;

  assign upd = ~freeze & ~clr;

  // Free-running timestamp; only the async reset clears it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!ap_rst_n) ts_q <= '0;
    else           ts_q <= ts_q + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_regs_t          ch_q;
    logic [CNT_W-1:0]  fifo_mem [DEPTH];
    logic [CNT_CW-1:0] count_d;
    logic              accept, done, empty, full, do_push, do_pop, lat_vld;
    logic [CNT_W-1:0]  lat;
    logic [CNT_W-1:0]  sel;

    assign accept  = ap_start[c] & ap_ready[c];
    assign done    = ap_done[c] & ap_continue[c];
    assign empty   = (ch_q.count == '0);
    assign full    = (ch_q.count == CNT_CW'(DEPTH));
    assign do_pop  = done & ~empty;
    // Accept+done on an empty FIFO is a zero-latency pass-through: nothing is stored.
    assign do_push = accept & ~(done & empty) & (~full | do_pop);
    assign lat_vld = done & (~empty | accept);
    assign lat     = empty ? '0 : ts_q - fifo_mem[ch_q.rd_ptr];
    assign count_d = ch_q.count + CNT_CW'(do_push) - CNT_CW'(do_pop);

    // NOTE: timestamp storage has no reset; an entry is only read once count marks it valid.
    always_ff @(posedge ap_clk) begin
      if (upd && do_push) fifo_mem[ch_q.wr_ptr] <= ts_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        ch_q <= ch_reset();
      end else if (clr) begin
        ch_q <= ch_reset();
      end else if (!freeze) begin
        ch_q.count <= count_d;
        if (do_push) ch_q.wr_ptr <= ch_q.wr_ptr + 1'b1;
        if (do_pop)  ch_q.rd_ptr <= ch_q.rd_ptr + 1'b1;
        if (accept)  ch_q.start_cnt <= sat_inc(ch_q.start_cnt);
        if (done)    ch_q.done_cnt  <= sat_inc(ch_q.done_cnt);
        if (ch_q.state != S_IDLE) ch_q.busy_cyc <= sat_inc(ch_q.busy_cyc);
`ifdef MON_STALL_CNT_EN
        if ((ap_done[c] & ~ap_continue[c]) | (ap_start[c] & ~ap_ready[c]))
          ch_q.stall_cyc <= sat_inc(ch_q.stall_cyc);
`endif
        if (lat_vld) begin
          ch_q.last_lat <= lat;
          if (lat < ch_q.min_lat) ch_q.min_lat <= lat;
          if (lat > ch_q.max_lat) ch_q.max_lat <= lat;
        end
        if (accept & full & ~do_pop) ch_q.ovf <= 1'b1;
        if (done & empty & ~accept)  ch_q.udf <= 1'b1;

        case (ch_q.state)
          S_IDLE: begin
            if (accept & ~done) begin
              ch_q.state <= S_BUSY;
              ch_q.busy  <= 1'b1;
            end
          end
          S_BUSY: begin
`ifdef MON_STALL_CNT_EN
            if (ap_done[c] & ~ap_continue[c]) begin
              ch_q.state <= S_STALL;
            end else
`endif
            if (done && count_d == '0) begin
              ch_q.state <= S_IDLE;
              ch_q.busy  <= 1'b0;
            end
          end
`ifdef MON_STALL_CNT_EN
          S_STALL: begin
            if (done) begin
              ch_q.state <= (count_d == '0) ? S_IDLE : S_BUSY;
              ch_q.busy  <= (count_d != '0);
            end
          end
`endif
          default: begin
            ch_q.state <= S_IDLE;
            ch_q.busy  <= 1'b0;
          end
        endcase
      end
    end

    always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      sel = '0;
      case (rd_reg)
        3'd0: sel = ch_q.start_cnt;
        3'd1: sel = ch_q.done_cnt;
        3'd2: sel = ch_q.last_lat;
        3'd3: sel = ch_q.min_lat;
        3'd4: sel = ch_q.max_lat;
        3'd5: sel = ch_q.busy_cyc;
`ifdef MON_STALL_CNT_EN
        3'd6: sel = ch_q.stall_cyc;
`endif
        3'd7: sel = CNT_W'({ch_q.ovf, ch_q.udf, ch_q.count});
        default: sel = '0;
      endcase
    end

    assign reg_word[c] = sel;
    assign ch_busy[c]  = ch_q.busy;
  end

  // Out-of-range channel indices match no entry and read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_word = reg_word[i];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (clr) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_word;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
